// File: rtl/lane_det_pkg.sv
// Shared types and width helpers for the lane-detection pipeline blocks.
package lane_det_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    FLUSH,
    EMIT
  } hpf_state_t;

  // Width that can hold values 0..w (column index or pixel count).
  function automatic int pos_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // Width that can hold a count 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/peak_topk_list.sv
// Sorted top-K list of (position, height) pairs; descending height, ties keep the
// earlier insertion ahead of later ones.
module peak_topk_list
  import lane_det_pkg::*;
#(
  parameter int MAX_POINTS = 5,
  parameter int POS_W      = 10,
  parameter int HEIGHT_W   = 10,
  localparam int IDX_W     = count_width(MAX_POINTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 ins_en,
  input  logic [POS_W-1:0]                     ins_pos,
  input  logic [HEIGHT_W-1:0]                  ins_height,
  output logic [MAX_POINTS-1:0][POS_W-1:0]     list_pos,
  output logic [MAX_POINTS-1:0][HEIGHT_W-1:0]  list_height,
  output logic [IDX_W-1:0]                     list_count
);

  logic [IDX_W-1:0] ins_idx;

  // Valid entries form a sorted prefix, so the last slot that is >= the candidate
  // gives the insertion index.
  always_comb begin
    // NOTE: assign a default before the loop so no path leaves ins_idx unassigned (no latch).
    ins_idx = '0;
    for (int i = 0; i < MAX_POINTS; i++) begin
      if (IDX_W'(i) < list_count && list_height[i] >= ins_height)
        ins_idx = IDX_W'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so the shift reads pre-edge slot values.
    if (rst) begin
      list_pos    <= '0;
      list_height <= '0;
      list_count  <= '0;
    end else if (clr) begin
      list_pos    <= '0;
      list_height <= '0;
      list_count  <= '0;
    end else if (ins_en && ins_idx < IDX_W'(MAX_POINTS)) begin
      if (ins_idx == '0) begin
        list_pos[0]    <= ins_pos;
        list_height[0] <= ins_height;
      end
      for (int i = 1; i < MAX_POINTS; i++) begin
        if (IDX_W'(i) == ins_idx) begin
          list_pos[i]    <= ins_pos;
          list_height[i] <= ins_height;
        end else if (IDX_W'(i) > ins_idx) begin
          list_pos[i]    <= list_pos[i-1];
          list_height[i] <= list_height[i-1];
        end
      end
      if (list_count < IDX_W'(MAX_POINTS))
        list_count <= list_count + IDX_W'(1);
    end
  end

endmodule

// File: rtl/histogram_peak_finder.sv
// Streams a column histogram, finds local maxima >= MIN_PEAK, keeps the MAX_POINTS
// highest and publishes them with a one-cycle peaks_valid pulse at end of line.
module histogram_peak_finder
  import lane_det_pkg::*;
#(
  parameter int IMG_WIDTH  = 416,
  parameter int IMG_HEIGHT = 416,
  parameter int MAX_POINTS = 5,
  parameter int MIN_PEAK   = 20,
  localparam int HIST_W    = pos_width(IMG_HEIGHT),
  localparam int OUT_W     = pos_width(IMG_WIDTH),
  localparam int CNT_W     = count_width(MAX_POINTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               hist_valid,
  output logic                               hist_ready,
  input  logic [HIST_W-1:0]                  hist_data,
  output logic [MAX_POINTS-1:0][OUT_W-1:0]   peak_pos,
  output logic [MAX_POINTS-1:0][OUT_W-1:0]   peak_height,
  output logic [CNT_W-1:0]                   peak_count,
  output logic                               peaks_valid
);

  localparam logic [31:0] SAT_MAX = (32'd1 << OUT_W) - 32'd1;

  hpf_state_t state, state_next;

  logic [OUT_W-1:0]  col_cnt;
  logic [HIST_W-1:0] left, cur;
  logic              accept, last_col;

  logic [HIST_W-1:0] cand_right;
  logic [OUT_W-1:0]  cand_pos;
  logic              ins_en;

  logic [MAX_POINTS-1:0][OUT_W-1:0]  list_pos;
  logic [MAX_POINTS-1:0][HIST_W-1:0] list_height;
  logic [CNT_W-1:0]                  list_count;

  assign accept   = hist_valid && hist_ready;
  assign last_col = (col_cnt == OUT_W'(IMG_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (accept && last_col) state_next = FLUSH;
      FLUSH:   state_next = EMIT;
      EMIT:    state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    hist_ready = (state == COLLECT);
  end

  // Column c-1 is judged when column c arrives; in FLUSH the right neighbour is the
  // virtual zero column past the edge.
  always_comb begin
    cand_right = (state == FLUSH) ? '0 : hist_data;
    cand_pos   = (state == FLUSH) ? OUT_W'(IMG_WIDTH - 1) : col_cnt - OUT_W'(1);
    ins_en     = ((state == COLLECT && accept && col_cnt != '0) || state == FLUSH)
                 && cur > left && cur >= cand_right && cur >= HIST_W'(MIN_PEAK);
  end

  peak_topk_list #(
    .MAX_POINTS (MAX_POINTS),
    .POS_W      (OUT_W),
    .HEIGHT_W   (HIST_W)
  ) u_list (
    .clk         (clk),
    .rst         (rst),
    .clr         (state == EMIT),
    .ins_en      (ins_en),
    .ins_pos     (cand_pos),
    .ins_height  (cur),
    .list_pos    (list_pos),
    .list_height (list_height),
    .list_count  (list_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt     <= '0;
      left        <= '0;
      cur         <= '0;
      peak_pos    <= '0;
      peak_height <= '0;
      peak_count  <= '0;
      peaks_valid <= 1'b0;
    end else begin
      peaks_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            left    <= cur;
            cur     <= hist_data;
            col_cnt <= col_cnt + OUT_W'(1);
          end
        end
        EMIT: begin
          left        <= '0;
          cur         <= '0;
          col_cnt     <= '0;
          peak_pos    <= list_pos;
          peak_count  <= list_count;
          peaks_valid <= 1'b1;
          // Heights are kept at full width internally and only clipped here.
          for (int i = 0; i < MAX_POINTS; i++) begin
            if (32'(list_height[i]) > SAT_MAX) peak_height[i] <= '1;
            else                               peak_height[i] <= OUT_W'(list_height[i]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_peak_finder.sv
// Self-checking bench for histogram_peak_finder against a whole-line reference model.
module tb_histogram_peak_finder;

  localparam int W       = 16;
  localparam int H       = 416;
  localparam int K       = 3;
  localparam int MINP    = 20;
  localparam int HIST_W  = $clog2(H) + 1;
  localparam int OUT_W   = $clog2(W) + 1;
  localparam int CNT_W   = $clog2(K + 1);
  localparam int SAT     = (1 << OUT_W) - 1;

  typedef int line_t [W];
  typedef int kvec_t [K];

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      hist_valid;
  logic                      hist_ready;
  logic [HIST_W-1:0]         hist_data;
  logic [K-1:0][OUT_W-1:0]   peak_pos;
  logic [K-1:0][OUT_W-1:0]   peak_height;
  logic [CNT_W-1:0]          peak_count;
  logic                      peaks_valid;

  int n_vec = 0;
  int n_bad = 0;

  histogram_peak_finder #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .MAX_POINTS (K),
    .MIN_PEAK   (MINP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hist_valid  (hist_valid),
    .hist_ready  (hist_ready),
    .hist_data   (hist_data),
    .peak_pos    (peak_pos),
    .peak_height (peak_height),
    .peak_count  (peak_count),
    .peaks_valid (peaks_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: judge every column with zero-valued virtual edges, then pick the K
  // best by (height desc, column asc).
  function automatic void model(input line_t h, output kvec_t pos, output kvec_t hgt,
                                output int cnt);
    int cp[$];
    int ch[$];
    for (int c = 0; c < W; c++) begin
      int l = (c == 0) ? 0 : h[c-1];
      int r = (c == W - 1) ? 0 : h[c+1];
      if (h[c] > l && h[c] >= r && h[c] >= MINP) begin
        cp.push_back(c);
        ch.push_back(h[c]);
      end
    end
    cnt = 0;
    for (int k = 0; k < K; k++) begin
      pos[k] = 0;
      hgt[k] = 0;
      if (cp.size() > 0) begin
        int b = 0;
        for (int j = 1; j < cp.size(); j++)
          if (ch[j] > ch[b]) b = j;
        pos[k] = cp[b];
        hgt[k] = (ch[b] > SAT) ? SAT : ch[b];
        cp.delete(b);
        ch.delete(b);
        cnt++;
      end
    end
  endfunction

  task automatic idle(input int n);
    hist_valid = 1'b0;
    hist_data  = HIST_W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the
  // accepting edge with hist_valid low.
  task automatic send_beat(input int d);
    int guard = 0;
    hist_valid = 1'b1;
    hist_data  = HIST_W'(d);
    @(negedge clk);
    while (!hist_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("hist_ready timeout", 0, 1);
    @(posedge clk);
    #1;
    hist_valid = 1'b0;
    hist_data  = HIST_W'($urandom);
  endtask

  task automatic check_outputs(input string name, input kvec_t pos, input kvec_t hgt,
                               input int cnt);
    check($sformatf("%s count", name), int'(peak_count), cnt);
    for (int k = 0; k < K; k++) begin
      check($sformatf("%s pos[%0d]", name, k), int'(peak_pos[k]), pos[k]);
      check($sformatf("%s height[%0d]", name, k), int'(peak_height[k]), hgt[k]);
    end
  endtask

  // Streams a full line, then checks the FLUSH/EMIT timing and the published list.
  // With hold_next, the first beat of the following line is presented during the
  // FLUSH/EMIT bubble and must be taken on the first ready cycle.
  task automatic run_line(input string name, input line_t h, input int gap_max,
                          input bit pre_accepted, input bit hold_next, input int next_h0);
    kvec_t pos, hgt;
    int cnt;
    model(h, pos, hgt, cnt);
    for (int c = (pre_accepted ? 1 : 0); c < W; c++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_beat(h[c]);
    end
    if (hold_next) begin
      hist_valid = 1'b1;
      hist_data  = HIST_W'(next_h0);
    end
    @(negedge clk);
    check($sformatf("%s ready t+1", name), int'(hist_ready), 0);
    check($sformatf("%s pvalid t+1", name), int'(peaks_valid), 0);
    @(negedge clk);
    check($sformatf("%s ready t+2", name), int'(hist_ready), 0);
    check($sformatf("%s pvalid t+2", name), int'(peaks_valid), 0);
    @(negedge clk);
    check($sformatf("%s ready t+3", name), int'(hist_ready), 1);
    check($sformatf("%s pvalid t+3", name), int'(peaks_valid), 1);
    check_outputs(name, pos, hgt, cnt);
    if (hold_next) begin
      @(posedge clk);
      #1;
      hist_valid = 1'b0;
      hist_data  = HIST_W'($urandom);
    end
    @(negedge clk);
    check($sformatf("%s pvalid t+4", name), int'(peaks_valid), 0);
    check($sformatf("%s hold count", name), int'(peak_count), cnt);
    @(posedge clk);
    #1;
  endtask

  function automatic line_t zero_line();
    line_t h;
    for (int c = 0; c < W; c++) h[c] = 0;
    return h;
  endfunction

  function automatic line_t rand_line();
    line_t h;
    int prev = 0;
    for (int c = 0; c < W; c++) begin
      int r = $urandom_range(0, 9);
      if (r < 4)      h[c] = $urandom_range(0, 25);
      else if (r < 6) h[c] = prev;
      else if (r < 9) h[c] = $urandom_range(0, 120);
      else            h[c] = H;
      prev = h[c];
    end
    return h;
  endfunction

  initial begin
    line_t h, h2;

    rst        = 1'b1;
    hist_valid = 1'b0;
    hist_data  = '0;
    repeat (2) @(negedge clk);
    check("reset ready", int'(hist_ready), 1);
    check("reset pvalid", int'(peaks_valid), 0);
    check("reset count", int'(peak_count), 0);
    check("reset pos", int'(peak_pos), 0);
    check("reset height", int'(peak_height), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    h = zero_line(); h[3] = 50; h[10] = 80;
    run_line("two_peaks", h, 0, 1'b0, 1'b0, 0);

    h = zero_line(); h[1] = 30; h[4] = 90; h[7] = 60; h[10] = 90; h[13] = 40;
    run_line("tie", h, 0, 1'b0, 1'b0, 0);

    h = zero_line(); h[0] = 70; h[15] = 65; h[6] = 50; h[7] = 50; h[8] = 50;
    run_line("edge_plateau", h, 0, 1'b0, 1'b0, 0);

    h = zero_line(); h[5] = 19;
    run_line("sub_threshold", h, 0, 1'b0, 1'b0, 0);

    h = zero_line(); h[4] = 20; h[9] = 31; h[12] = 32;
    run_line("threshold_sat", h, 0, 1'b0, 1'b0, 0);

    h  = rand_line();
    h2 = rand_line();
    run_line("gaps_hold", h, 3, 1'b0, 1'b1, h2[0]);
    run_line("held_col0", h2, 3, 1'b1, 1'b0, 0);

    h = rand_line();
    for (int c = 0; c < 10; c++) send_beat(h[c]);
    rst = 1'b1;
    @(negedge clk);
    check("midline rst ready", int'(hist_ready), 1);
    check("midline rst pvalid", int'(peaks_valid), 0);
    check("midline rst count", int'(peak_count), 0);
    check("midline rst pos", int'(peak_pos), 0);
    check("midline rst height", int'(peak_height), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    h = zero_line(); h[12] = 40;
    run_line("after_rst", h, 0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      h = rand_line();
      run_line($sformatf("rand%0d", n), h, (n % 2 == 1) ? 2 : 0, 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
